// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with req/ack memory handshake, skid buffer and IF/ID register
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pcwrite,
    input  logic        i_idIfwrite,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_ifId_instr,
    output logic [31:0] o_ifId_pcplus4,
    output logic        o_ifId_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] skid;
    logic        adv, redir, ack;
    logic [31:0] target, pc_next4;

    assign adv      = i_pcwrite & i_idIfwrite;
    assign redir    = i_branch_taken | i_jump;
    assign target   = i_branch_taken ? i_branch_target : i_jump_target;
    assign ack      = o_imem_req & i_imem_ack;
    assign pc_next4 = o_pc + 32'd4;

    // Fetch FSM: PC, fetch address, request, skid buffer and IF/ID register all advance here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= FETCH;
            o_pc           <= PC_RESET;
            o_imem_addr    <= PC_RESET;
            o_imem_req     <= 1'b0;
            skid           <= '0;
            o_ifId_instr   <= '0;
            o_ifId_pcplus4 <= '0;
            o_ifId_valid   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redir) begin
                        o_pc           <= target;
                        o_ifId_instr   <= '0;
                        o_ifId_pcplus4 <= '0;
                        o_ifId_valid   <= 1'b0;
                        // an unanswered request cannot be withdrawn, so wait it out in DROP
                        if (o_imem_req && !ack) begin
                            state <= DROP;
                        end else begin
                            o_imem_addr <= target;
                            o_imem_req  <= 1'b1;
                        end
                    end else if (!o_imem_req) begin
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= o_pc;
                    end else if (ack && adv) begin
                        o_ifId_instr   <= i_imem_rdata;
                        o_ifId_pcplus4 <= pc_next4;
                        o_ifId_valid   <= 1'b1;
                        o_pc           <= pc_next4;
                        o_imem_addr    <= pc_next4;
                    end else if (ack) begin
                        skid       <= i_imem_rdata;
                        o_imem_req <= 1'b0;
                        state      <= HOLD;
                    end else if (adv) begin
                        o_ifId_instr   <= '0;
                        o_ifId_pcplus4 <= pc_next4;
                        o_ifId_valid   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        o_pc           <= target;
                        o_imem_addr    <= target;
                        o_imem_req     <= 1'b1;
                        o_ifId_instr   <= '0;
                        o_ifId_pcplus4 <= '0;
                        o_ifId_valid   <= 1'b0;
                        state          <= FETCH;
                    end else if (adv) begin
                        o_ifId_instr   <= skid;
                        o_ifId_pcplus4 <= pc_next4;
                        o_ifId_valid   <= 1'b1;
                        o_pc           <= pc_next4;
                        o_imem_addr    <= pc_next4;
                        o_imem_req     <= 1'b1;
                        state          <= FETCH;
                    end
                end
                DROP: begin
                    o_pc <= redir ? target : o_pc;
                    if (ack) begin
                        o_imem_addr <= redir ? target : o_pc;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch-stage bench against a queue-based reference model
module tb_if_stage;
    localparam logic [31:0] PC_RESET = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcwrite, idifwrite, branch_taken, jump, imem_ack;
    logic [31:0] branch_target, jump_target, imem_rdata;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, pc, ifid_instr, ifid_pcplus4;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_addr, m_instr, m_pp4;
    logic        m_req, m_valid, m_drop;
    logic [31:0] skid_q[$];

    always #5 clk = ~clk;

    if_stage #(.PC_RESET(PC_RESET)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pcwrite(pcwrite), .i_idIfwrite(idifwrite),
        .i_branch_taken(branch_taken), .i_branch_target(branch_target),
        .i_jump(jump), .i_jump_target(jump_target),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_pc(pc), .o_ifId_instr(ifid_instr),
        .o_ifId_pcplus4(ifid_pcplus4), .o_ifId_valid(ifid_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        check("pc", pc, m_pc);
        check("req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) check("addr", imem_addr, m_addr);
        check("instr", ifid_instr, m_instr);
        check("pcplus4", ifid_pcplus4, m_pp4);
        check("valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    endtask

    task automatic model_reset();
        m_pc = PC_RESET; m_addr = PC_RESET; m_req = 1'b0; m_drop = 1'b0;
        m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
        skid_q.delete();
    endtask

    task automatic model_step();
        logic        a, go, rd;
        logic [31:0] tgt;
        a   = m_req & imem_ack;
        go  = pcwrite & idifwrite;
        rd  = branch_taken | jump;
        tgt = branch_taken ? branch_target : jump_target;
        if (rst) model_reset();
        else if (m_drop) begin
            if (rd) m_pc = tgt;
            if (a) begin m_drop = 1'b0; m_addr = m_pc; end
        end else if (rd) begin
            m_pc = tgt; m_instr = '0; m_pp4 = '0; m_valid = 1'b0;
            skid_q.delete();
            if (m_req && !a) m_drop = 1'b1;
            else begin m_addr = tgt; m_req = 1'b1; end
        end else if (skid_q.size() != 0) begin
            if (go) begin
                m_instr = skid_q.pop_front(); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_addr = m_pc; m_req = 1'b1;
            end
        end else if (!m_req) begin
            m_req = 1'b1; m_addr = m_pc;
        end else if (a) begin
            if (go) begin
                m_instr = imem_rdata; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_addr = m_pc;
            end else begin
                skid_q.push_back(imem_rdata); m_req = 1'b0;
            end
        end else if (go) begin
            m_instr = '0; m_pp4 = m_pc + 32'd4; m_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFC;
            1: return 32'h0000_0200;
            2: return 32'h0000_0400;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic cycle(input logic r, input int ack_pct, input int stall_pct, input int redir_pct);
        rst           = r;
        pcwrite       = $urandom_range(0, 99) >= stall_pct;
        idifwrite     = $urandom_range(0, 99) >= stall_pct;
        branch_taken  = $urandom_range(0, 99) < redir_pct;
        jump          = $urandom_range(0, 99) < redir_pct;
        branch_target = pick_target();
        jump_target   = pick_target();
        imem_ack      = r ? 1'($urandom_range(0, 1)) : (imem_req && $urandom_range(0, 99) < ack_pct);
        imem_rdata    = $urandom;
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        int ack_pct, stall_pct, redir_pct;
        rst = 1'b1; pcwrite = 1'b1; idifwrite = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; imem_ack = 1'b1; imem_rdata = '0;
        model_reset();
        @(negedge clk);
        compare();
        repeat (2) cycle(1'b1, 100, 0, 0);
        repeat (6) cycle(1'b0, 100, 0, 0);
        rst = 1'b0; pcwrite = 1'b1; idifwrite = 1'b1; jump = 1'b1; branch_taken = 1'b0;
        jump_target = 32'hFFFF_FFFC; imem_ack = imem_req; imem_rdata = $urandom;
        model_step();
        @(negedge clk);
        compare();
        repeat (4) cycle(1'b0, 100, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            case (i / 1000)
                0: begin ack_pct = 100; stall_pct = 0;  redir_pct = 2;  end
                1: begin ack_pct = 50;  stall_pct = 30; redir_pct = 5;  end
                2: begin ack_pct = 30;  stall_pct = 50; redir_pct = 10; end
                default: begin ack_pct = 80; stall_pct = 20; redir_pct = 3; end
            endcase
            cycle((i % 700) >= 698, ack_pct, stall_pct, redir_pct);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
